// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: operand-fetch / write-back wrapper around an external
// combinational alu. One register-to-register instruction is accepted at a
// time (IDLE -> EXEC -> IDLE). Operands are sampled at accept and the alu
// result (or the LOADI immediate) is written back one edge later.
module alu_regfile_ctrl #(
    parameter int N    = 8,
    parameter int REGS = 4,
    parameter int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_dst,
    input  logic [AW-1:0] instr_srca,
    input  logic [AW-1:0] instr_srcb,
    input  logic [N-1:0]  instr_imm,
    output logic [N-1:0]  alu_in0,
    output logic [N-1:0]  alu_in1,
    output logic [3:0]    alu_op,
    input  logic [N-1:0]  alu_out,
    output logic [N-1:0]  result,
    output logic          result_valid,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    localparam logic [3:0] OP_LOADI = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            accept;
    logic            wb_en;
    logic [N-1:0]    wb_value;
    logic [REGS-1:0] wr_sel;

    logic [N-1:0]    regs_reg [REGS];
    logic [N-1:0]    alu_in0_reg;
    logic [N-1:0]    alu_in1_reg;
    logic [3:0]      alu_op_reg;
    logic [AW-1:0]   dst_reg;
    logic [N-1:0]    imm_reg;
    logic [N-1:0]    result_reg;
    logic            result_valid_reg;

    // State register; reset abandons any in-flight write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake decode: accept only in IDLE, write back in EXEC.
    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        accept      = 1'b0;
        wb_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                wb_en      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // LOADI bypasses the alu; every other op takes whatever the alu produced.
    assign wb_value = (alu_op_reg == OP_LOADI) ? imm_reg : alu_out;

    // One-hot write select per register.
    for (genvar gi = 0; gi < REGS; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wb_en && (dst_reg == AW'(gi));
    end

    // Register file: cleared on reset, written at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wb_value;
                end
            end
        end
    end

    // Operand capture at accept and result reporting at write-back.
    // The next accept is at least two edges away from the previous one, so
    // operand reads always see completed writes and no bypass is required.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_in0_reg      <= '0;
            alu_in1_reg      <= '0;
            alu_op_reg       <= '0;
            dst_reg          <= '0;
            imm_reg          <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                alu_in0_reg <= regs_reg[instr_srca];
                alu_in1_reg <= regs_reg[instr_srcb];
                alu_op_reg  <= instr_op;
                dst_reg     <= instr_dst;
                imm_reg     <= instr_imm;
            end
            if (wb_en) begin
                result_reg <= wb_value;
            end
            result_valid_reg <= wb_en;
        end
    end

    assign alu_in0      = alu_in0_reg;
    assign alu_in1      = alu_in1_reg;
    assign alu_op       = alu_op_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign rd_data      = regs_reg[rd_addr];

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Bench for alu_regfile_ctrl: a behavioural alu closes the loop on alu_out,
// a register model predicts every write-back and a scoreboard queue matches
// each result_valid pulse against the prediction and its expected cycle.
module tb_alu_regfile_ctrl;

    localparam int N    = 8;
    localparam int REGS = 4;
    localparam int AW   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_op;
    logic [AW-1:0] instr_dst;
    logic [AW-1:0] instr_srca;
    logic [AW-1:0] instr_srcb;
    logic [N-1:0]  instr_imm;
    logic [N-1:0]  alu_in0;
    logic [N-1:0]  alu_in1;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_out;
    logic [N-1:0]  result;
    logic          result_valid;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;

    typedef struct {
        logic [AW-1:0] dst;
        logic [N-1:0]  val;
        int            cyc;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] model_r [REGS];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           pulses      = 0;

    always #5 clk = ~clk;

    alu_regfile_ctrl #(.N(N), .REGS(REGS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst),
        .instr_srca(instr_srca), .instr_srcb(instr_srcb), .instr_imm(instr_imm),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
        .result(result), .result_valid(result_valid),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Lab alu: ADD, SUB, AND, OR, XOR, anything else passes in0.
    function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb alu_out = alu_fn(alu_op, alu_in0, alu_in1);

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each pulse must match the oldest prediction and its cycle.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (result_valid === 1'b1) begin
            pulses++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result_valid: got result %h at cycle %0d, required no pulse",
                         result, cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.val || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL result: got %h at cycle %0d, required %h at cycle %0d",
                             result, cyc, e.val, e.cyc);
                end
            end
        end
    end

    // Model one accepted instruction: predict write-back and queue it.
    task automatic push_expected(input logic [3:0] op, input logic [AW-1:0] dst,
                                 input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic [N-1:0] imm,
                                 output logic [N-1:0] ea, output logic [N-1:0] eb);
        logic [N-1:0] wb;
        ea = model_r[a];
        eb = model_r[b];
        wb = (op == 4'd15) ? imm : alu_fn(op, ea, eb);
        sb.push_back('{dst: dst, val: wb, cyc: cyc + 2});
        model_r[dst] = wb;
        $display("txn op=%0d dst=R%0d srca=R%0d srcb=R%0d imm=%h -> expect %h", op, dst, a, b,
                 imm, wb);
    endtask

    // Present one instruction, wait (bounded) for accept; returns in the EXEC cycle.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [N-1:0] imm);
        logic [N-1:0] ea, eb;
        bit done;
        instr_op = op; instr_dst = dst; instr_srca = a; instr_srcb = b; instr_imm = imm;
        instr_valid = 1'b1;
        done = 1'b0;
        ea = '0;
        eb = '0;
        for (int guard = 0; guard < 20 && !done; guard++) begin
            if (instr_ready === 1'b1) begin
                push_expected(op, dst, a, b, imm, ea, eb);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL accept_timeout: instr_ready never high, required accept within 20 cycles");
        end else if (alu_in0 !== ea || alu_in1 !== eb || alu_op !== op) begin
            miscompares++;
            $display("FAIL operands: got in0=%h in1=%h op=%0d, required in0=%h in1=%h op=%0d",
                     alu_in0, alu_in1, alu_op, ea, eb, op);
        end
    endtask

    // Issue and step past the write edge so rd_data shows the new value.
    task automatic issue_wb(input logic [3:0] op, input logic [AW-1:0] dst,
                            input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [N-1:0] imm);
        issue(op, dst, a, b, imm);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0; instr_op = '0; instr_dst = '0; instr_srca = '0; instr_srcb = '0;
        instr_imm = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i < REGS; i++) model_r[i] = '0;
        for (int i = 0; i < REGS; i++) begin
            rd_addr = AW'(i);
            #1;
            vectors++;
            if (rd_data !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_reg R%0d: got %h, required 00", i, rd_data);
            end
        end
        vectors++;
        if (instr_ready !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: got ready=%b result_valid=%b, required 1/0",
                     instr_ready, result_valid);
        end
        vectors++;
        if (alu_in0 !== 8'h00 || alu_in1 !== 8'h00 || alu_op !== 4'd0 || result !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got in0=%h in1=%h op=%0d result=%h, required all 0",
                     alu_in0, alu_in1, alu_op, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loadi_add();
        issue_wb(4'd15, 2'd1, 2'd0, 2'd0, 8'h05);
        issue_wb(4'd15, 2'd2, 2'd0, 2'd0, 8'h03);
        issue_wb(4'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        rd_addr = 2'd3; #1;
        vectors++;
        if (rd_data !== 8'h08) begin
            miscompares++;
            $display("FAIL add_R3: got %h, required 08", rd_data);
        end
    endtask

    task automatic test_sub_wrap();
        issue_wb(4'd1, 2'd0, 2'd2, 2'd1, 8'h00);
        rd_addr = 2'd0; #1;
        vectors++;
        if (rd_data !== 8'hFE) begin
            miscompares++;
            $display("FAIL sub_R0: got %h, required fe", rd_data);
        end
        issue_wb(4'd15, 2'd1, 2'd0, 2'd0, 8'hFF);
        issue_wb(4'd15, 2'd2, 2'd0, 2'd0, 8'h01);
        issue_wb(4'd0, 2'd1, 2'd1, 2'd2, 8'h00);
        rd_addr = 2'd1; #1;
        vectors++;
        if (rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL add_wrap_R1: got %h, required 00", rd_data);
        end
    endtask

    task automatic test_logic();
        logic [N-1:0] want [4];
        logic [AW-1:0] dsts [4];
        want = '{8'h30, 8'hFC, 8'hCC, 8'hF0};
        dsts = '{2'd3, 2'd3, 2'd0, 2'd2};
        issue_wb(4'd15, 2'd1, 2'd0, 2'd0, 8'hF0);
        issue_wb(4'd15, 2'd2, 2'd0, 2'd0, 8'h3C);
        issue_wb(4'd2, 2'd3, 2'd1, 2'd2, 8'h00);
        rd_addr = dsts[0]; #1;
        vectors++;
        if (rd_data !== want[0]) begin
            miscompares++; $display("FAIL and: got %h, required %h", rd_data, want[0]);
        end
        issue_wb(4'd3, 2'd3, 2'd1, 2'd2, 8'h00);
        rd_addr = dsts[1]; #1;
        vectors++;
        if (rd_data !== want[1]) begin
            miscompares++; $display("FAIL or: got %h, required %h", rd_data, want[1]);
        end
        issue_wb(4'd4, 2'd0, 2'd1, 2'd2, 8'h00);
        rd_addr = dsts[2]; #1;
        vectors++;
        if (rd_data !== want[2]) begin
            miscompares++; $display("FAIL xor: got %h, required %h", rd_data, want[2]);
        end
        issue_wb(4'd7, 2'd2, 2'd1, 2'd3, 8'h55);
        rd_addr = dsts[3]; #1;
        vectors++;
        if (rd_data !== want[3]) begin
            miscompares++; $display("FAIL op7_pass: got %h, required %h", rd_data, want[3]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]    ops  [3];
        logic [AW-1:0] dsts [3];
        logic [AW-1:0] sas  [3];
        logic [AW-1:0] sbs  [3];
        logic [N-1:0]  ea, eb;
        int acc [3];
        int n, p0;
        ops  = '{4'd0, 4'd1, 4'd4};
        dsts = '{2'd0, 2'd3, 2'd1};
        sas  = '{2'd1, 2'd0, 2'd1};
        sbs  = '{2'd3, 2'd1, 2'd2};
        acc  = '{0, 0, 0};
        p0 = pulses;
        n = 0;
        instr_op = ops[0]; instr_dst = dsts[0]; instr_srca = sas[0]; instr_srcb = sbs[0];
        instr_imm = 8'h00;
        instr_valid = 1'b1;
        for (int guard = 0; guard < 40 && n < 3; guard++) begin
            if (instr_ready === 1'b1) begin
                push_expected(ops[n], dsts[n], sas[n], sbs[n], 8'h00, ea, eb);
                acc[n] = cyc;
                n++;
                @(posedge clk); #1;
                vectors++;
                if (instr_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ready_in_exec: got %b, required 0", instr_ready);
                end
                if (n < 3) begin
                    instr_op = ops[n]; instr_dst = dsts[n];
                    instr_srca = sas[n]; instr_srcb = sbs[n];
                end else begin
                    instr_valid = 1'b0;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        instr_valid = 1'b0;
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL b2b_accepts: got %0d accepts, required 3", n);
        end else if (acc[1] - acc[0] != 2 || acc[2] - acc[1] != 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got gaps %0d,%0d, required 2,2",
                     acc[1] - acc[0], acc[2] - acc[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (pulses - p0 != 3) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d, required 3", pulses - p0);
        end
    endtask

    task automatic test_reset_in_exec();
        int p0;
        issue_wb(4'd15, 2'd1, 2'd0, 2'd0, 8'h11);
        issue_wb(4'd15, 2'd2, 2'd0, 2'd0, 8'h22);
        issue(4'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        reset = 1'b1;
        sb.delete();
        p0 = pulses;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < REGS; i++) model_r[i] = '0;
        vectors++;
        if (instr_ready !== 1'b1 || result_valid !== 1'b0 || result !== 8'h00) begin
            miscompares++;
            $display("FAIL exec_reset_state: got ready=%b rv=%b result=%h, required 1/0/00",
                     instr_ready, result_valid, result);
        end
        for (int i = 0; i < REGS; i++) begin
            rd_addr = AW'(i);
            #1;
            vectors++;
            if (rd_data !== 8'h00) begin
                miscompares++;
                $display("FAIL exec_reset_R%0d: got %h, required 00", i, rd_data);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (pulses != p0) begin
            miscompares++;
            $display("FAIL exec_reset_pulse: got %0d pulses, required 0", pulses - p0);
        end
        issue_wb(4'd15, 2'd2, 2'd0, 2'd0, 8'h5A);
        rd_addr = 2'd2; #1;
        vectors++;
        if (rd_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL post_reset_loadi: got %h, required 5a", rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_loadi_add();
        test_sub_wrap();
        test_logic();
        test_back_to_back();
        test_reset_in_exec();
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
